// File: rtl/forwarding_ctrl.sv
// forwarding_ctrl: hazard detection and operand-forwarding control for a
// classic five-stage pipeline. Tracks the destinations of the instructions
// currently in EX and MEM, stalls one cycle on a load-use pair, and produces
// registered forwarding selects aligned with the consumer's first EX cycle.
//
// Optional feature: define FWD_STALL_COUNT_EN to build a saturating 16-bit
// counter of stall cycles on stall_cnt. Without it stall_cnt is tied to 0.
//
// Forwarding select encoding (fwd_a / fwd_b):
//   0 = register file, 1 = EX/MEM ALU result,
//   2 = MEM/WB ALU result, 3 = MEM/WB memory data out.

module forwarding_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_we,
  input  logic        id_load,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RF     = 2'd0;
  localparam logic [1:0] SEL_EX_ALU = 2'd1;
  localparam logic [1:0] SEL_WB_ALU = 2'd2;
  localparam logic [1:0] SEL_WB_MEM = 2'd3;

  state_t state;
  state_t state_next;

  // Scoreboard slot for the instruction currently in EX
  logic       ex_valid;
  logic [4:0] ex_dst;
  logic       ex_we;
  logic       ex_load;

  // Scoreboard slot for the instruction currently in MEM
  logic       mem_valid;
  logic [4:0] mem_dst;
  logic       mem_we;
  logic       mem_load;

  logic       ex_hit_rs;
  logic       ex_hit_rt;
  logic       mem_hit_rs;
  logic       mem_hit_rt;
  logic       hazard;
  logic       advance;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  // Register $0 is hard-wired to zero, so a write to it never produces a value
  // worth forwarding.
  function automatic logic slot_match(input logic       valid,
                                      input logic       we,
                                      input logic [4:0] dst,
                                      input logic [4:0] src);
    return valid && we && (dst == src) && (src != 5'd0);
  endfunction

  // Pick the forwarding source for one operand; the EX producer is younger
  // than the MEM producer and therefore wins. A load still in EX cannot be
  // forwarded from (its data is not ready), so it falls through to MEM.
  function automatic logic [1:0] pick_sel(input logic used,
                                          input logic ex_hit,
                                          input logic ex_is_load,
                                          input logic mem_hit,
                                          input logic mem_is_load);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (ex_hit && !ex_is_load)
        sel = SEL_EX_ALU;
      else if (mem_hit && mem_is_load)
        sel = SEL_WB_MEM;
      else if (mem_hit)
        sel = SEL_WB_ALU;
    end
    return sel;
  endfunction

  // Source-register matches against both scoreboard slots
  always_comb begin
    ex_hit_rs  = slot_match(ex_valid,  ex_we,  ex_dst,  id_rs);
    ex_hit_rt  = slot_match(ex_valid,  ex_we,  ex_dst,  id_rt);
    mem_hit_rs = slot_match(mem_valid, mem_we, mem_dst, id_rs);
    mem_hit_rt = slot_match(mem_valid, mem_we, mem_dst, id_rt);
  end

  // Load-use hazard: the instruction in EX is a load feeding a used operand
  always_comb begin
    hazard = id_valid && ex_load &&
             ((id_use_rs && ex_hit_rs) || (id_use_rt && ex_hit_rt));
  end

  // Stall FSM next-state and stall output; a flush or reset suppresses stall
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_RUN: begin
        if (hazard && !flush && !rst) begin
          stall      = 1'b1;
          state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // The ID instruction moves into EX only when it is neither held nor killed
  always_comb begin
    advance = !stall && !flush;
  end

  // Forwarding selects for the instruction about to enter EX; bubbles get 0
  always_comb begin
    fwd_a_next = SEL_RF;
    fwd_b_next = SEL_RF;
    if (advance && id_valid) begin
      fwd_a_next = pick_sel(id_use_rs, ex_hit_rs, ex_load, mem_hit_rs, mem_load);
      fwd_b_next = pick_sel(id_use_rt, ex_hit_rt, ex_load, mem_hit_rt, mem_load);
    end
  end

  // Stall FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  // EX slot: capture the advancing ID instruction, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_dst   <= 5'd0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
    end else if (advance && id_valid) begin
      ex_valid <= 1'b1;
      ex_dst   <= id_dst;
      ex_we    <= id_we;
      ex_load  <= id_load;
    end else begin
      ex_valid <= 1'b0;
      ex_dst   <= 5'd0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
    end
  end

  // MEM slot: always takes whatever was in EX, bubbles included
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_dst   <= 5'd0;
      mem_we    <= 1'b0;
      mem_load  <= 1'b0;
    end else begin
      mem_valid <= ex_valid;
      mem_dst   <= ex_dst;
      mem_we    <= ex_we;
      mem_load  <= ex_load;
    end
  end

  // Registered forwarding selects, valid during the instruction's EX cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= SEL_RF;
      fwd_b <= SEL_RF;
    end else begin
      fwd_a <= fwd_a_next;
      fwd_b <= fwd_b_next;
    end
  end

`ifdef FWD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= 16'd0;
    else if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_forwarding_ctrl.sv
// tb_forwarding_ctrl: directed scenarios plus randomized traffic for
// forwarding_ctrl, checked against a history-based reference model.

module tb_forwarding_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  id_dst;
  logic        id_we;
  logic        id_load;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  forwarding_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_we(id_we), .id_load(id_load), .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the last two instructions that entered EX, youngest first
  typedef struct {
    bit       v;
    bit       we;
    bit       ld;
    bit [4:0] dst;
  } instr_t;

  instr_t      hist[2];
  bit          m_prev_stall;
  bit   [1:0]  m_fwd_a;
  bit   [1:0]  m_fwd_b;
  bit   [15:0] m_cnt;
  logic        seen_stall;

  function automatic bit writes(instr_t e, bit [4:0] s);
    return e.v && e.we && (s != 5'd0) && (e.dst == s);
  endfunction

  // Youngest usable producer wins; a load sitting in EX has no data yet
  function automatic bit [1:0] ref_fwd(bit used, bit [4:0] s);
    if (!used) return 2'd0;
    for (int k = 0; k < 2; k++) begin
      if (writes(hist[k], s)) begin
        if (k == 0 && hist[k].ld) continue;
        if (k == 0) return 2'd1;
        return hist[k].ld ? 2'd3 : 2'd2;
      end
    end
    return 2'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of ID inputs, check stall before the edge and the
  // registered outputs just after it, advancing the reference model.
  task automatic applyStimulus(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                               input bit urs, input bit urt, input bit [4:0] dst,
                               input bit we, input bit ld, input bit fl, input bit r);
    bit     haz;
    bit     exp_stall;
    instr_t ent;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_we = we; id_load = ld; flush = fl; rst = r;
    #2;
    haz = v && hist[0].ld &&
          ((urs && writes(hist[0], rs)) || (urt && writes(hist[0], rt)));
    exp_stall = !r && !m_prev_stall && haz && !fl;
    seen_stall = stall;
    checkOutput("stall", stall, 16'(exp_stall));
    @(posedge clk);
    if (r) begin
      hist[0] = '{default: 0};
      hist[1] = '{default: 0};
      m_fwd_a = 0; m_fwd_b = 0; m_cnt = 0; m_prev_stall = 0;
    end else begin
      ent = '{default: 0};
      m_fwd_a = 0; m_fwd_b = 0;
      if (!exp_stall && !fl && v) begin
        ent = '{v: 1'b1, we: we, ld: ld, dst: dst};
        m_fwd_a = ref_fwd(urs, rs);
        m_fwd_b = ref_fwd(urt, rt);
      end
`ifdef FWD_STALL_COUNT_EN
      if (exp_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      hist[1] = hist[0];
      hist[0] = ent;
      m_prev_stall = exp_stall;
    end
    #1;
    checkOutput("fwd_a", 16'(fwd_a), 16'(m_fwd_a));
    checkOutput("fwd_b", 16'(fwd_b), 16'(m_fwd_b));
    checkOutput("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    hist[0] = '{default: 0};
    hist[1] = '{default: 0};
    m_prev_stall = 0; m_fwd_a = 0; m_fwd_b = 0; m_cnt = 0;
    rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dst = 0; id_we = 0; id_load = 0; flush = 0;

    do_reset();
    do_reset();
    checkOutput("reset_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("reset_cnt", stall_cnt, 16'd0);

    // ALU producer immediately followed by consumer on rs
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    applyStimulus(1, 3, 2, 1, 1, 9, 1, 0, 0, 0);
    checkOutput("dir_ex_fwd_a", 16'(fwd_a), 16'd1);
    checkOutput("dir_ex_nostall", 16'(seen_stall), 16'd0);

    // ALU producer, independent instruction, then consumer on rt
    do_reset();
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    applyStimulus(1, 6, 7, 1, 1, 8, 1, 0, 0, 0);
    applyStimulus(1, 10, 3, 1, 1, 11, 1, 0, 0, 0);
    checkOutput("dir_mem_fwd_b", 16'(fwd_b), 16'd2);

    // Load-use pair: one stall cycle then memory-data forwarding
    do_reset();
    applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    applyStimulus(1, 5, 2, 1, 1, 12, 1, 0, 0, 0);
    checkOutput("dir_ld_stall", 16'(seen_stall), 16'd1);
    applyStimulus(1, 5, 2, 1, 1, 12, 1, 0, 0, 0);
    checkOutput("dir_ld_stall_once", 16'(seen_stall), 16'd0);
    checkOutput("dir_ld_fwd_a", 16'(fwd_a), 16'd3);
`ifdef FWD_STALL_COUNT_EN
    checkOutput("dir_ld_cnt", stall_cnt, 16'd1);
`else
    checkOutput("dir_ld_cnt", stall_cnt, 16'd0);
`endif

    // Two writers of $4 in flight: youngest (EX) wins
    do_reset();
    applyStimulus(1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
    applyStimulus(1, 4, 0, 1, 0, 13, 1, 0, 0, 0);
    checkOutput("dir_prio_fwd_a", 16'(fwd_a), 16'd1);

    // Writes to $0 are never forwarded, even from a load
    do_reset();
    applyStimulus(1, 1, 2, 1, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 14, 1, 0, 0, 0);
    checkOutput("dir_zero_stall", 16'(seen_stall), 16'd0);
    checkOutput("dir_zero_fwd_a", 16'(fwd_a), 16'd0);

    // Load-use hazard coinciding with flush: flush wins
    do_reset();
    applyStimulus(1, 1, 0, 1, 0, 6, 1, 1, 0, 0);
    applyStimulus(1, 6, 6, 1, 1, 15, 1, 0, 1, 0);
    checkOutput("dir_flush_stall", 16'(seen_stall), 16'd0);
    checkOutput("dir_flush_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("dir_flush_fwd_b", 16'(fwd_b), 16'd0);

    // Reset arriving while the FSM sits in STALL
    applyStimulus(1, 1, 0, 1, 0, 6, 1, 1, 0, 0);
    applyStimulus(1, 6, 0, 1, 0, 15, 1, 0, 0, 0);
    checkOutput("dir_rst_pre_stall", 16'(seen_stall), 16'd1);
    applyStimulus(1, 6, 0, 1, 0, 15, 1, 0, 0, 1);
    checkOutput("dir_rst_stall", 16'(seen_stall), 16'd0);
    checkOutput("dir_rst_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("dir_rst_cnt", stall_cnt, 16'd0);
    applyStimulus(1, 6, 6, 1, 1, 16, 1, 0, 0, 0);
    checkOutput("dir_post_rst_fwd", 16'(fwd_a), 16'd0);

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) != 0,
                    5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    nop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
